reg_addr_arbiter: RTL and testbench
===================================

REG_ADDR_ARBITER -- requirements
Module: reg_addr_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 9, number of requesters sharing the 5-bit register-address select path (fixed at 9; sel width 4).
REQ-002 SHALL have parameter: AW, 5, address width per requester.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  9  request per requester; bit i = requester i.
REQ-007 addr_in  input  45  requester addresses; addr_in[5i+4:5i] belongs to requester i.
REQ-008 grant  output  9  one-hot grant, registered.
REQ-009 sel  output  4  index of current/last owner, registered, drives the 9:1 address mux.
REQ-010 out_addr  output  5  addr_in slice selected by sel while busy, else 0.
REQ-011 busy  output  1  high while a grant is held.
REQ-012 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-013 SHALL implement two states: IDLE, GRANT.
REQ-014 IDLE, req != 0: SHALL select owner = first set req bit searching last+1, last+2, ... wrapping modulo 9; next cycle GRANT, grant[owner]=1, sel=owner, busy=1, last=owner.
REQ-015 Grant latency SHALL be exactly 1 cycle from the edge where req is sampled.
REQ-016 IDLE, req == 0: SHALL remain IDLE; grant=0, busy=0, sel holds last value.
REQ-017 GRANT: SHALL hold owner while req[owner]=1; other req bits ignored, never preempt.
REQ-018 GRANT, req[owner]=0 sampled: next cycle IDLE, grant=0, busy=0; no new grant in that cycle (one dead cycle between owners).
REQ-019 grant SHALL never have more than one bit set.
REQ-020 out_addr SHALL combinationally follow addr_in[5*sel+4:5*sel] when busy=1, 0 when busy=0.
REQ-021 Pointer wrap: last=8 SHALL search starting at requester 0.
REQ-022 Simultaneous owner release and other requests SHALL still pass through IDLE before next grant.
REQ-023 timeout SHALL be 0 whenever the timeout feature is absent.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, grant=0, sel=0, busy=0, timeout=0, last=8, hold counter=0.
REQ-025 reset asserted mid-GRANT SHALL drop grant on that edge; first grant after reset deassertion goes to lowest set req index.

Configuration
REQ-026 Macro HOLD_TIMEOUT_EN defined: 4-bit hold counter cleared on grant, incremented each GRANT cycle; after 16 GRANT cycles with req[owner] still high, SHALL force IDLE, pulse timeout for one cycle coincident with grant drop; round-robin then proceeds from owner+1 (owner regranted only if sole requester).
REQ-027 Macro HOLD_TIMEOUT_EN undefined: no counter, unlimited hold, timeout tied 0.

Verification
REQ-028 reset then req=9'h001, addr_in slice0=5'd17 -> cycle+1: grant=9'h001, sel=0, busy=1, out_addr=17.
REQ-029 req=9'h1FF held, each owner releases after 2 cycles -> grant order 0,1,...,8,0 with one IDLE cycle between owners.
REQ-030 last=8 after owner 8 releases, req=9'h101 -> grant=9'h001 (wrap), then 9'h100.
REQ-031 owner 3 holding, req=9'h1FF, reset pulsed -> next edge grant=0, sel=0, busy=0; after release of reset grant=9'h001.
REQ-032 HOLD_TIMEOUT_EN, req=9'h004 held forever -> grant 9'h004 for 16 cycles, timeout=1 with grant=0, then regrant 9'h004; with req=9'h024 next grant is 9'h020.
REQ-033 without HOLD_TIMEOUT_EN, req=9'h004 held 100 cycles -> grant stays 9'h004, timeout stays 0.

Source files
------------

// File: rtl/reg_addr_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters ownership of a shared register-address path.
// Optional hold timeout: define HOLD_TIMEOUT_EN to force release after 16 consecutive GRANT cycles.
module reg_addr_arbiter #(
    parameter int NREQ = 9,
    parameter int AW   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      addr_in,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic [AW-1:0]           out_addr,
    output logic                    busy,
    output logic                    timeout
);
    localparam int SW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [SW-1:0]   sel_q;
    logic [SW-1:0]   last_q;
    logic            busy_q;
    logic [SW-1:0]   owner_d;
`ifdef HOLD_TIMEOUT_EN
    logic [3:0]      cnt_q;
    logic            timeout_q;
`endif

    // Round-robin search starting just after the previous owner, wrapping modulo NREQ.
    always_comb begin
        owner_d = '0;
        for (int k = NREQ; k >= 1; k--) begin
            automatic logic [SW-1:0] idx = SW'((int'(last_q) + k) % NREQ);
            if (req[idx]) owner_d = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            last_q    <= SW'(NREQ - 1);
`ifdef HOLD_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
                        sel_q   <= owner_d;
                        last_q  <= owner_d;
                        busy_q  <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Release always passes through IDLE, so owners are separated by a dead cycle.
                    if (!req[sel_q]) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
`ifdef HOLD_TIMEOUT_EN
                    else if (cnt_q == 4'hF) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [AW-1:0] slot [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = addr_in[g*AW +: AW];
    end

    assign out_addr = busy_q ? slot[sel_q] : '0;
    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
`ifdef HOLD_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_addr_arbiter.sv
// Directed bench for reg_addr_arbiter: stimulus queues expected grants/timeouts, a negedge monitor checks them.
module tb_reg_addr_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  req;
    logic [44:0] addr_in;
    logic [8:0]  grant;
    logic [3:0]  sel;
    logic [4:0]  out_addr;
    logic        busy;
    logic        timeout;

    reg_addr_arbiter #(.NREQ(9), .AW(5)) dut (
        .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
        .grant(grant), .sel(sel), .out_addr(out_addr), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct { int owner; int at; } exp_t;
    exp_t exp_q[$];
    int   tmo_q[$];
    logic [4:0] addr_tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int owner, input int at);
        exp_t e;
        e.owner = owner;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Request r, expect owner one edge later, hold for 'hold' grant cycles, then drive r_after.
    task automatic grant_seq(input logic [8:0] r, input int owner, input int hold, input logic [8:0] r_after);
        tick();
        req = r;
        expect_grant(owner, cyc + 1);
        repeat (hold) tick();
        req = r_after;
    endtask

    // Monitor: per-cycle invariants plus scoreboard pops on new grants and timeout pulses.
    initial begin
        logic [8:0] prev;
        exp_t e;
        int t;
        prev = '0;
        forever begin
            @(negedge clk);
            chk("onehot", int'($onehot0(grant)), 1);
            chk("busy_vs_grant", int'(busy), int'(grant != 0));
            if (grant == 0) chk("idle_addr", int'(out_addr), 0);
            if (grant != 0 && grant != prev) begin
                chk("dead_cycle", int'(prev), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got %0h expected none (cycle %0d)", grant, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", int'(grant), 1 << e.owner);
                    chk("sel", int'(sel), e.owner);
                    chk("out_addr", int'(out_addr), int'(addr_tbl[e.owner]));
                    chk("grant_cycle", cyc, e.at);
                end
            end
            if (timeout) begin
                if (tmo_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_timeout: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    t = tmo_q.pop_front();
                    chk("timeout_cycle", cyc, t);
                    chk("timeout_grant", int'(grant), 0);
                end
            end
            prev = grant;
        end
    end

    initial begin
        for (int i = 0; i < 9; i++) addr_tbl[i] = 5'((i * 7 + 3) % 32);
        addr_tbl[0] = 5'd17;
        for (int i = 0; i < 9; i++) addr_in[i*5 +: 5] = addr_tbl[i];
        reset = 1'b1;
        req   = '0;
        repeat (3) tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        reset = 1'b0;

        // First grant after reset, then out_addr tracks addr_in combinationally.
        tick();
        req = 9'h001;
        expect_grant(0, cyc + 1);
        tick();
        tick();
        addr_in[4:0] = 5'd9;
        #1;
        chk("addr_follow", int'(out_addr), 9);
        addr_in[4:0] = addr_tbl[0];
        tick();
        req = '0;
        tick();
        tick();

        // Full rotation 0..8,0 with 2-cycle holds.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            automatic int o = k % 9;
            grant_seq(9'h1FF, o, 2, (k == 9) ? 9'h000 : (9'h1FF & ~(9'd1 << o)));
        end
        tick();
        tick();

        // Pointer wrap from owner 8.
        grant_seq(9'h100, 8, 2, 9'h000);
        grant_seq(9'h101, 0, 2, 9'h100);
        grant_seq(9'h100, 8, 2, 9'h000);
        tick();
        tick();

        // Reset while owner 3 holds.
        do_reset();
        tick();
        req = 9'h008;
        expect_grant(3, cyc + 1);
        tick();
        req = 9'h1FF;
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_timeout", int'(timeout), 0);
        reset = 1'b0;
        expect_grant(0, cyc + 1);
        tick();
        tick();
        req = '0;
        tick();
        tick();

`ifdef HOLD_TIMEOUT_EN
        begin
            int c;
            tick();
            req = 9'h004;
            c = cyc;
            expect_grant(2, c + 1);
            tmo_q.push_back(c + 17);
            expect_grant(2, c + 18);
            tmo_q.push_back(c + 34);
            expect_grant(5, c + 35);
            repeat (20) tick();
            req = 9'h024;
            repeat (16) tick();
            req = '0;
            tick();
            tick();
        end
`else
        tick();
        req = 9'h004;
        expect_grant(2, cyc + 1);
        repeat (100) tick();
        chk("long_hold_grant", int'(grant), 9'h004);
        chk("long_hold_timeout", int'(timeout), 0);
        req = '0;
        tick();
        tick();
`endif

        repeat (5) tick();
        chk("pending_grants", exp_q.size(), 0);
        chk("pending_timeouts", tmo_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
